// File: rtl/roulette_pkg.sv
// -----------------------------------------------------------------------------
// roulette_pkg
// Shared definitions for the roulette wheel spinner:
//   - spin_state_t     : FSM state encoding (IDLE / SPIN / SETTLE / DONE)
//   - RAND_W           : width of the winning number and of the LFSR
//   - LFSR_TAP_A/B     : feedback taps of the 5-bit maximal-length LFSR
//   - LFSR_LOCKUP_FIX  : value forced into the LFSR if it ever reads zero
//   - safe_seed()      : maps an illegal all-zero seed onto LFSR_LOCKUP_FIX
// -----------------------------------------------------------------------------
package roulette_pkg;

    localparam int RAND_W = 5;

    // Fibonacci feedback: new bit 0 = lfsr[4] ^ lfsr[2] (period 31)
    localparam int LFSR_TAP_A = 4;
    localparam int LFSR_TAP_B = 2;

    localparam logic [RAND_W-1:0] LFSR_LOCKUP_FIX = 5'b00001;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SPIN   = 2'b01,
        SETTLE = 2'b10,
        DONE   = 2'b11
    } spin_state_t;

    // The all-zero state is a fixed point of the LFSR, so never load it.
    function automatic logic [RAND_W-1:0] safe_seed(input logic [RAND_W-1:0] seed);
        return (seed == '0) ? LFSR_LOCKUP_FIX : seed;
    endfunction

endpackage

// File: rtl/roulette_spinner_lfsr5.sv
// -----------------------------------------------------------------------------
// lfsr5
// 5-bit Fibonacci LFSR with enable, seed load on reset and a lock-up guard.
// Ports:
//   clk  in  1      : clock, rising edge
//   rst  in  1      : asynchronous active-high reset, loads the (safe) seed
//   en   in  1      : advance the LFSR by one step this cycle
//   q    out RAND_W : current LFSR register
// -----------------------------------------------------------------------------
module lfsr5
    import roulette_pkg::*;
#(
    parameter logic [RAND_W-1:0] SEED = 5'b00001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [RAND_W-1:0] q
);

    localparam logic [RAND_W-1:0] SEED_SAFE = safe_seed(SEED);

    logic [RAND_W-1:0] lfsr_reg;
    logic [RAND_W-1:0] lfsr_next;
    logic [RAND_W-1:0] shift_val;

    // Shift towards the MSB, feedback enters at bit 0
    genvar gi;
    generate
        for (gi = 1; gi < RAND_W; gi++) begin : g_shift
            assign shift_val[gi] = lfsr_reg[gi-1];
        end
    endgenerate
    assign shift_val[0] = lfsr_reg[LFSR_TAP_A] ^ lfsr_reg[LFSR_TAP_B];

    // Zero can only appear through an upset; recover regardless of en.
    always_comb begin
        lfsr_next = lfsr_reg;
        if (lfsr_reg == '0) begin
            lfsr_next = LFSR_LOCKUP_FIX;
        end else if (en) begin
            lfsr_next = shift_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= SEED_SAFE;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign q = lfsr_reg;

endmodule

// File: rtl/roulette_spinner.sv
// -----------------------------------------------------------------------------
// roulette_spinner
// Produces the roulette winning number (1..31). A rising edge on spin_req
// starts a wheel spin: the LFSR runs one step per clock for SPIN_CYCLES
// cycles, then one step every 4 clocks for SETTLE_STEPS steps, then stops and
// its value is latched onto randnum with a one-cycle rand_valid strobe. While
// idle the LFSR free-runs, so the result depends on when the button is hit.
// Ports:
//   Clock      in  1 : clock, rising edge
//   reset_n    in  1 : asynchronous active-high reset (historic name)
//   spin_req   in  1 : spin button level, synchronous to Clock
//   randnum    out 5 : latched winning number, 0 only before the first spin
//   rand_valid out 1 : one-cycle strobe when randnum updates
//   busy       out 1 : spin in progress (registered, ends with the strobe)
//   wheel_pos  out 5 : live LFSR value for wheel animation
// -----------------------------------------------------------------------------
module roulette_spinner
    import roulette_pkg::*;
#(
    parameter logic [RAND_W-1:0] SEED         = 5'b00001,
    parameter int                SPIN_CYCLES  = 32,
    parameter int                SETTLE_STEPS = 4
) (
    input  logic              Clock,
    input  logic              reset_n,
    input  logic              spin_req,
    output logic [RAND_W-1:0] randnum,
    output logic              rand_valid,
    output logic              busy,
    output logic [RAND_W-1:0] wheel_pos
);

    localparam logic [7:0] SPIN_LAST   = 8'(SPIN_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_STEPS - 1);

    spin_state_t       state_reg, state_next;
    logic              spin_d_reg;
    logic              spin_edge;
    logic [7:0]        cnt_reg, cnt_next;
    logic [1:0]        div_reg, div_next;
    logic              lfsr_en;
    logic              latch_result;
    logic [RAND_W-1:0] lfsr_q;
    logic [RAND_W-1:0] randnum_reg;
    logic              rand_valid_reg;
    logic              busy_reg;

    // Holding the button must give exactly one spin
    assign spin_edge = spin_req & ~spin_d_reg;

    lfsr5 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk (Clock),
        .rst (reset_n),
        .en  (lfsr_en),
        .q   (lfsr_q)
    );

    // cnt counts fast steps in SPIN and slow steps in SETTLE.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        div_next     = div_reg;
        lfsr_en      = 1'b0;
        latch_result = 1'b0;
        case (state_reg)
            IDLE: begin
                lfsr_en = 1'b1;
                if (spin_edge) begin
                    state_next = SPIN;
                    cnt_next   = '0;
                end
            end
            SPIN: begin
                lfsr_en = 1'b1;
                if (cnt_reg == SPIN_LAST) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                    div_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            SETTLE: begin
                div_next = div_reg + 2'd1;
                // One slow step every fourth clock
                if (div_reg == 2'd3) begin
                    lfsr_en = 1'b1;
                    if (cnt_reg == SETTLE_LAST) begin
                        state_next = DONE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
            end
            DONE: begin
                // LFSR holds so randnum matches the wheel shown in DONE
                latch_result = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge reset_n) begin
        if (reset_n) begin
            state_reg      <= IDLE;
            spin_d_reg     <= 1'b0;
            cnt_reg        <= '0;
            div_reg        <= '0;
            randnum_reg    <= '0;
            rand_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            spin_d_reg     <= spin_req;
            cnt_reg        <= cnt_next;
            div_reg        <= div_next;
            rand_valid_reg <= latch_result;
            if (latch_result) begin
                randnum_reg <= lfsr_q;
            end
            // Registered one cycle behind the state so busy covers the
            // strobe cycle and drops right after it.
            busy_reg <= (state_reg != IDLE);
        end
    end

    assign randnum    = randnum_reg;
    assign rand_valid = rand_valid_reg;
    assign busy       = busy_reg;
    assign wheel_pos  = lfsr_q;

endmodule

// File: doc/roulette_spinner.md
# roulette_spinner

Upstream stage for the roulette game FSM. It produces the 5-bit winning number `randnum`, always in the range 1..31. A rising edge on the player's spin button starts a timed "wheel spin": a 5-bit maximal-length LFSR runs fast, then slows, then stops. The final value is latched onto `randnum` with a one-cycle `rand_valid` strobe. The LFSR also free-runs while idle, so the result depends on when the player presses the button.

## Interface
- `SEED`, default `5'b00001`: LFSR load value on reset. It must be nonzero; a value of 0 is forced to `5'b00001`.
- `SPIN_CYCLES`, default 32: number of fast-phase steps, one per clock. Legal range is 1..255.
- `SETTLE_STEPS`, default 4: number of slow-phase steps, one every 4 clocks. Legal range is 1..15.

- `Clock`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: reset, asynchronous and active-high (the codebase name is kept).
- `spin_req`, in, 1: spin button level, synchronous to `Clock`.
- `randnum`, out, 5: latched winning number, range 1..31; held between spins.
- `rand_valid`, out, 1: one-cycle strobe when `randnum` updates.
- `busy`, out, 1: high in the SPIN, SETTLE and DONE states.
- `wheel_pos`, out, 5: live LFSR value, used to animate the wheel on LEDs/HEX.

## Operation
- LFSR (Fibonacci form): `next = {lfsr[3:0], lfsr[4]^lfsr[2]}`.
  - Period is 31 and the all-zero state is never visited.
  - Lock-up guard: if the LFSR ever reads 0, the next value is `5'b00001`.
- Edge detect: `spin_d <= spin_req`; `spin_edge = spin_req & ~spin_d`.
  - Holding the button produces only one spin.
- States: IDLE, SPIN, SETTLE, DONE.
  - **IDLE**: the LFSR advances every cycle. `spin_edge` → SPIN, with `cnt` set to 0.
  - **SPIN**: the LFSR advances every cycle and `cnt` increments. On the cycle where `cnt == SPIN_CYCLES-1` (after the advance) → SETTLE, with `cnt` and `div` set to 0.
  - **SETTLE**: a 2-bit `div` increments every cycle. The LFSR advances only when `div == 3`. After `SETTLE_STEPS` such advances → DONE.
  - **DONE**: `randnum <= lfsr`, `rand_valid <= 1` for exactly one cycle, the LFSR holds, and the state → IDLE.
- `spin_edge` is ignored in SPIN, SETTLE and DONE; a new request is not queued.
- `wheel_pos` always equals the current LFSR register.
- Reset values:
  - state IDLE
  - LFSR = `SEED`
  - `randnum = 0`; this is the only time it can be 0, and it means "no spin yet".
  - `rand_valid = 0`
  - `busy = 0`
  - `spin_d = 0`
  - `cnt = 0`, `div = 0`
- Reset during any state aborts the spin immediately. No `rand_valid` is issued and `randnum` returns to 0.

## Timing
- Let t be the posedge at which IDLE sees `spin_edge` (the state is registered as SPIN at t).
- `busy` is high from t+1 through the cycle containing the `rand_valid` strobe.
- SPIN occupies `SPIN_CYCLES` cycles; SETTLE occupies `4*SETTLE_STEPS` cycles.
- `randnum` and `rand_valid` are registered: `rand_valid` is high during the cycle after posedge t+`SPIN_CYCLES`+`4*SETTLE_STEPS`+1.
  - With defaults, `rand_valid` is high between posedges t+49 and t+50.
- `busy` drops in the cycle after the strobe. A new edge can be accepted on the first IDLE cycle.
- If the button is pressed again in the cycle `busy` falls, it is accepted only if `spin_req` was low for at least one sampled cycle before the press.
- Consumers sample `randnum` when `rand_valid` is high; the value is stable until the next strobe or reset.

## Structure
- Shared package `roulette_pkg` holds:
  - the state enum (IDLE=2'b00, SPIN=2'b01, SETTLE=2'b10, DONE=2'b11);
  - `RAND_W = 5`;
  - the LFSR tap constants (bits 4 and 2);
  - `LFSR_LOCKUP_FIX = 5'b00001`.
- Sub-module `lfsr5` holds the register, `en` input, seed load on reset, and the lock-up guard. The FSM, counters and output registers live in `roulette_spinner`.
- Expected size is about 150–250 lines in total.

## Test plan
- **Reset**: assert `reset_n` asynchronously mid-cycle, then release.
  - Outputs immediately read `randnum=0`, `rand_valid=0`, `busy=0`, `wheel_pos=5'b00001`.
  - Over the following IDLE cycles `wheel_pos` steps 00010, 00100, 01001, 10010, 00101.
- **Period**: stay in IDLE for 31 cycles.
  - `wheel_pos` returns to its starting value.
  - All 31 nonzero values are seen exactly once and 0 never appears.
- **Spin latency** (defaults): hold `spin_req` high for 100 cycles.
  - Exactly one `rand_valid` pulse, at edge t+49.
  - `randnum` equals the `wheel_pos` value of the DONE cycle and is nonzero.
  - `busy` is high for exactly 49 cycles.
- **Ignored re-press**: toggle `spin_req` low/high at t+5 and t+30.
  - Still exactly one `rand_valid`, at t+49.
  - A clean press at t+52 gives a second strobe at t+52+49.
- **Reset mid-SETTLE**: assert reset at t+40.
  - No strobe occurs; `randnum=0`, `busy=0`, `wheel_pos=SEED`.
  - The next press spins normally.
- **Parameters**: `SPIN_CYCLES=1`, `SETTLE_STEPS=1`, `SEED=0`.
  - Strobe at t+6.
  - `wheel_pos` after reset is `5'b00001`.
